// File: rtl/stream_upsize_arb_if.sv
// rtl/stream_upsize_arb_if.sv - source-side and upsizer-side stream bundle for stream_upsize_arb
interface stream_upsize_arb_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SRC        = 4
);
  localparam int ID_WIDTH = $clog2(N_SRC);

  logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC];
  logic [N_SRC-1:0]        s_last_i;
  logic [N_SRC-1:0]        s_valid_i;
  logic [N_SRC-1:0]        s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic [ID_WIDTH-1:0]     m_id_o;
  logic [N_SRC-1:0]        grant_o;
  logic                    busy_o;

  // Arbiter view: consumes source beats, drives the shared upsizer port.
  modport slave (
    input  s_data_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, grant_o, busy_o
  );

  // Environment view: sources plus the downstream upsizer.
  modport master (
    output s_data_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o, m_id_o, grant_o, busy_o
  );
endinterface

// File: rtl/stream_upsize_arb.sv
// rtl/stream_upsize_arb.sv - packet-granular round-robin arbiter in front of stream_upsize
module stream_upsize_arb #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SRC        = 4
) (
  input  logic                clk,
  input  logic                rst,
  stream_upsize_arb_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(N_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [N_SRC-1:0]    grant_q, grant_d;

  logic [ID_WIDTH-1:0] winner;
  logic                any_valid;
  logic                last_hs;

  // Round-robin search from rr_ptr; scanning backwards lets the nearest requester win.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_SRC;
      if (bus.s_valid_i[ID_WIDTH'(idx)]) begin
        winner    = ID_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

  // Final beat of the granted packet is accepted by the upsizer.
  always_comb begin
    last_hs = 1'b0;
    if (state_q == BUSY) begin
      last_hs = bus.s_valid_i[id_q] & bus.m_ready_i & bus.s_last_i[id_q];
    end
  end

  // Next-state: grant locks on entry to BUSY and is released only by the last-beat handshake.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    grant_d  = grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = BUSY;
          id_d    = winner;
          grant_d = N_SRC'(1) << winner;
        end
      end
      BUSY: begin
        if (last_hs) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (id_q == ID_WIDTH'(N_SRC - 1)) ? '0 : id_q + ID_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Zero-latency mux of the granted source onto the upsizer port; nothing moves in IDLE.
  always_comb begin
    bus.m_data_o  = '0;
    bus.m_last_o  = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.s_ready_o = '0;
    if (state_q == BUSY) begin
      bus.m_data_o  = bus.s_data_i[id_q];
      bus.m_last_o  = bus.s_last_i[id_q];
      bus.m_valid_o = bus.s_valid_i[id_q];
      bus.s_ready_o = grant_q & {N_SRC{bus.m_ready_i}};
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.m_id_o  = id_q;
  assign bus.busy_o  = (state_q == BUSY);

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      grant_q  <= grant_d;
    end
  end
endmodule

// File: tb/tb_stream_upsize_arb.sv
// tb/tb_stream_upsize_arb.sv - scoreboard bench with packet-level round-robin model for stream_upsize_arb
module tb_stream_upsize_arb;
  localparam int TW = 4;
  localparam int NS = 4;

  typedef struct {
    logic [TW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            id;
    logic [TW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int              len;
    logic [4*TW-1:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_upsize_arb_if #(.T_DATA_WIDTH(TW), .N_SRC(NS)) bus ();

  stream_upsize_arb #(.T_DATA_WIDTH(TW), .N_SRC(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t src_q [NS][$];
  pkt_t  pend  [NS][$];
  exp_t  exp_q [$];
  int    model_ptr;
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en    = 1'b0;
  bit    rand_gaps = 1'b0;
  int    gap_after [NS];
  int    gap_len   [NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Queue one packet on a source: stimulus beats for the driver, whole packet for the model.
  task automatic add_pkt(input int src, input int len, input logic [4*TW-1:0] d);
    pkt_t p;
    p.len  = len;
    p.data = d;
    pend[src].push_back(p);
    for (int b = 0; b < len; b++) begin
      src_q[src].push_back('{data: d[TW*b +: TW], last: (b == len - 1)});
    end
  endtask

  // Packet order from the round-robin rule: every source with a pending packet is requesting.
  task automatic model_commit();
    pkt_t p;
    int   s;
    forever begin
      s = -1;
      for (int k = 0; k < NS; k++) begin
        if (s < 0 && pend[(model_ptr + k) % NS].size() > 0) s = (model_ptr + k) % NS;
      end
      if (s < 0) break;
      p = pend[s].pop_front();
      for (int b = 0; b < p.len; b++) begin
        exp_q.push_back('{id: s, data: p.data[TW*b +: TW], last: (b == p.len - 1)});
      end
      model_ptr = (s + 1) % NS;
    end
  endtask

  task automatic drain(input string name, input bit rnd_ready);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk); #2;
      if (rnd_ready) bus.m_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.busy_o) done = 1'b1;
    end
    @(posedge clk); #2;
    bus.m_ready_i = 1'b1;
    chk({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic wait_hs(input string name, input int id);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk); #1;
      if (bus.m_valid_o && bus.m_ready_i && bus.m_id_o == 2'(id)) ok = 1'b1;
    end
    chk({name, "_hs_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Source driver: presents queued beats, pops on handshake, inserts mid-packet gaps.
  initial begin : driver
    bit    hs    [NS];
    int    nbeat [NS];
    int    hold  [NS];
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      bus.s_valid_i[i] = 1'b0;
      bus.s_last_i[i]  = 1'b0;
      bus.s_data_i[i]  = '0;
      nbeat[i] = 0;
      hold[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) hs[i] = bus.s_valid_i[i] && bus.s_ready_o[i];
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (rst) begin
          nbeat[i] = 0;
          hold[i]  = 0;
        end else if (hs[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          if (b.last) begin
            nbeat[i] = 0;
          end else begin
            nbeat[i]++;
            if (rand_gaps) hold[i] = $urandom_range(0, 2);
            else if (nbeat[i] == gap_after[i]) hold[i] = gap_len[i];
          end
        end
        if (hold[i] > 0) begin
          hold[i]--;
          bus.s_valid_i[i] = 1'b0;
        end else begin
          bus.s_valid_i[i] = (src_q[i].size() > 0);
        end
        if (src_q[i].size() > 0) begin
          bus.s_data_i[i] = src_q[i][0].data;
          bus.s_last_i[i] = src_q[i][0].last;
        end else begin
          bus.s_data_i[i] = '0;
          bus.s_last_i[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks routing/idle rules.
  initial begin : monitor
    bit   expect_idle;
    exp_t e;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (expect_idle) begin
          chk("bubble_busy", 32'(bus.busy_o), 32'd0);
          chk("bubble_valid", 32'(bus.m_valid_o), 32'd0);
          expect_idle = 1'b0;
        end
        if (bus.busy_o) begin
          chk("grant_onehot", 32'(bus.grant_o), 32'(1) << bus.m_id_o);
          chk("s_ready_route", 32'(bus.s_ready_o), bus.m_ready_i ? (32'(1) << bus.m_id_o) : 32'd0);
          chk("m_valid_mux", 32'(bus.m_valid_o), 32'(bus.s_valid_i[bus.m_id_o]));
        end else begin
          chk("idle_grant", 32'(bus.grant_o), 32'd0);
          chk("idle_ready", 32'(bus.s_ready_o), 32'd0);
          chk("idle_valid", 32'(bus.m_valid_o), 32'd0);
          chk("idle_data", 32'(bus.m_data_o), 32'd0);
        end
        if (bus.m_valid_o && bus.m_ready_i) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got id %0d data %0h, required no beat", bus.m_id_o, bus.m_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("beat_id", 32'(bus.m_id_o), e.id);
            chk("beat_data", 32'(bus.m_data_o), 32'(e.data));
            chk("beat_last", 32'(bus.m_last_o), 32'(e.last));
            if (e.last) expect_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [TW-1:0] ref_d;
    logic [1:0]    ref_id;
    int            gapc;
    rst = 1'b1;
    bus.m_ready_i = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < NS; i++) begin
      gap_after[i] = -1;
      gap_len[i]   = 0;
    end

    // Reset held with every source valid.
    for (int i = 0; i < NS; i++) src_q[i].push_back('{data: 4'(i + 1), last: 1'b1});
    repeat (2) begin
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant_o), 32'd0);
      chk("rst_ready", 32'(bus.s_ready_o), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
    end
    for (int i = 0; i < NS; i++) src_q[i].delete();
    @(posedge clk); #2;
    rst = 1'b0;
    bus.m_ready_i = 1'b1;
    mon_en = 1'b1;

    // Single source: src2 sends A,B,C.
    add_pkt(2, 3, 16'h0CBA);
    model_commit();
    @(negedge clk);
    @(negedge clk);
    chk("t2_bubble_busy", 32'(bus.busy_o), 32'd0);
    chk("t2_bubble_valid", 32'(bus.m_valid_o), 32'd0);
    @(negedge clk);
    chk("t2_id", 32'(bus.m_id_o), 32'd2);
    chk("t2_grant", 32'(bus.grant_o), 32'h4);
    chk("t2_beat_a", 32'(bus.m_data_o), 32'hA);
    @(negedge clk);
    chk("t2_beat_b", 32'(bus.m_data_o), 32'hB);
    @(negedge clk);
    chk("t2_beat_c", 32'(bus.m_data_o), 32'hC);
    chk("t2_last", 32'(bus.m_last_o), 32'd1);
    @(negedge clk);
    chk("t2_busy_fall", 32'(bus.busy_o), 32'd0);
    drain("t2", 1'b0);

    // rr_ptr=3 after src2: src3 must beat src0.
    add_pkt(0, 1, 16'($urandom()));
    add_pkt(3, 1, 16'($urandom()));
    model_commit();
    drain("t2b", 1'b0);
    add_pkt(2, 1, 16'($urandom()));
    model_commit();
    drain("t2c", 1'b0);

    // Wrap with src3 idle, then src0 drops valid for 2 cycles mid-packet.
    gap_after[0] = 1;
    gap_len[0]   = 2;
    add_pkt(0, 4, 16'($urandom()));
    model_commit();
    gapc = 0;
    for (int c = 0; c < 60 && (exp_q.size() > 0 || bus.busy_o); c++) begin
      @(negedge clk); #1;
      if (bus.busy_o && !bus.s_valid_i[0]) begin
        gapc++;
        chk("t5_gap_valid", 32'(bus.m_valid_o), 32'd0);
        chk("t5_gap_grant", 32'(bus.grant_o), 32'h1);
      end
    end
    chk("t5_gap_cycles", 32'(gapc), 32'd2);
    gap_after[0] = -1;
    drain("t5", 1'b0);

    // Backpressure on src1 with src0/src3 waiting.
    add_pkt(1, 4, 16'($urandom()));
    add_pkt(0, 1, 16'($urandom()));
    add_pkt(3, 1, 16'($urandom()));
    model_commit();
    wait_hs("t4", 1);
    @(posedge clk); #2;
    bus.m_ready_i = 1'b0;
    @(negedge clk); #1;
    ref_d  = bus.m_data_o;
    ref_id = bus.m_id_o;
    chk("t4_stall_data", 32'(ref_d), 32'(exp_q[0].data));
    chk("t4_stall_ready", 32'(bus.s_ready_o), 32'd0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("t4_hold_data", 32'(bus.m_data_o), 32'(ref_d));
      chk("t4_hold_id", 32'(bus.m_id_o), 32'(ref_id));
      chk("t4_hold_ready", 32'(bus.s_ready_o), 32'd0);
      chk("t4_hold_grant", 32'(bus.grant_o), 32'h2);
    end
    @(posedge clk); #2;
    bus.m_ready_i = 1'b1;
    drain("t4", 1'b0);

    // Round robin from reset: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NS; i++) add_pkt(i, 2, 16'($urandom()));
    add_pkt(0, 2, 16'($urandom()));
    model_commit();
    drain("t3", 1'b0);

    // Reset during beat 2 of 4.
    add_pkt(1, 4, 16'($urandom()));
    model_commit();
    wait_hs("t6", 1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_grant", 32'(bus.grant_o), 32'd0);
    chk("t6_m_valid", 32'(bus.m_valid_o), 32'd0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    model_ptr = 0;
    add_pkt(3, 1, 16'($urandom()));
    add_pkt(0, 1, 16'($urandom()));
    model_commit();
    drain("t6", 1'b0);

    // Randomized rounds with gaps and random backpressure.
    rand_gaps = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NS; i++) begin
        int n;
        n = $urandom_range(0, 3) + ((i == r % NS) ? 1 : 0);
        for (int j = 0; j < n; j++) add_pkt(i, $urandom_range(1, 4), 16'($urandom()));
      end
      model_commit();
      drain("rand", 1'b1);
    end
    rand_gaps = 1'b0;

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
